jg_threshold_detector: RTL
==========================

Name: jg_threshold_detector

Overview:
- Parametrised, registered successor to the team's 3-bit truth-table detector, which produces X = (ABC >= 5) and Y = (ABC == 0).
- Samples an unsigned WIDTH-bit input under a valid strobe and produces a registered zero flag y.
- Produces a debounced threshold flag x that changes state only after HOLD consecutive qualifying samples, and emits one-cycle edge pulses when x changes.
- Sits between an input sampler and downstream control logic.

Parameters:
- WIDTH, 3, input sample width in bits (>= 1).
- HI_THRESH, 5, unsigned level at or above which a sample counts as "high"; must be <= 2^WIDTH-1.
- LO_THRESH, 4, release level, used only when HYSTERESIS_EN is defined; must be <= HI_THRESH.
- HOLD, 1, number of consecutive qualifying valid samples needed to change x (>= 1). HOLD=1 gives immediate switching. The counter width is a derived localparam, clog2(HOLD+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is sampled this cycle.
- in_data  input  WIDTH  unsigned sample.
- out_valid  output  1  one-cycle pulse: x/y updated from the previous valid sample.
- x  output  1  debounced threshold flag.
- y  output  1  zero flag: 1 when the last valid sample == 0.
- x_rise  output  1  one-cycle pulse when x goes 0->1.
- x_fall  output  1  one-cycle pulse when x goes 1->0.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset: x=0, y=0, out_valid=0, x_rise=0, x_fall=0, state=LOW, cnt=0. Reset wins over a simultaneous in_valid. A reset asserted mid-debounce discards the partial count.
- Latency: 1 cycle. On a cycle with in_valid=1, the next edge sets out_valid=1 and updates y, x and the pulses. When in_valid=0, out_valid=0, x_rise=0 and x_fall=0 next cycle; x, y, state and cnt hold.
- Idle cycles: in_valid=0 cycles do not break a consecutive run; cnt holds.
- Sample qualifiers (unsigned compare, full WIDTH):
  - above = (in_data >= HI_THRESH).
  - below = !above without the feature; see Optional Feature otherwise.
- y: y <= (in_data == 0) on every valid sample, independent of the FSM.
- FSM, evaluated only on valid samples; cnt saturates at HOLD and never exceeds it:
  - LOW (x=0):
    - above and HOLD==1 -> HIGH, x_rise=1.
    - above and HOLD>1 -> PEND_HI, cnt=1.
    - otherwise stay.
  - PEND_HI (x=0):
    - above -> cnt+1; if cnt+1==HOLD -> HIGH, cnt=0, x_rise=1.
    - not above -> LOW, cnt=0.
  - HIGH (x=1):
    - below and HOLD==1 -> LOW, x_fall=1.
    - below and HOLD>1 -> PEND_LO, cnt=1.
    - otherwise stay.
  - PEND_LO (x=1):
    - below -> cnt+1; if cnt+1==HOLD -> LOW, cnt=0, x_fall=1.
    - not below -> HIGH, cnt=0.
- x is a registered function of state: 1 in HIGH and PEND_LO, else 0. x_rise and x_fall are never both 1.
- With WIDTH=3, HI_THRESH=5, HOLD=1 and no macro, after each valid sample x/y equal the 3-bit detector's X/Y for that sample.
- Illegal state encodings recover to LOW with cnt=0.

Optional Feature:
- Macro: JG_THRESHOLD_DETECTOR_HYSTERESIS_EN.
- Defined: below = (in_data < LO_THRESH). Samples in [LO_THRESH, HI_THRESH) are neither above nor below:
  - in HIGH: stay.
  - in PEND_LO: return to HIGH, cnt=0.
  - in PEND_HI: return to LOW, cnt=0.
- Undefined: LO_THRESH is ignored and below = (in_data < HI_THRESH).

Test Plan:
- Defaults, no macro. Sweep in_data 0..7 with in_valid=1 each cycle -> one cycle later (x,y) = (0,1),(0,0),(0,0),(0,0),(0,0),(1,0),(1,0),(1,0); x_rise once at the sample 5 response; out_valid high throughout.
- HOLD=3. Samples 6,6,2,6,6,6 -> x stays 0 until the response to the 6th sample, when x=1 and x_rise=1. The 2 aborts the run.
- HOLD=3, x=1. Samples 1, idle, idle, 0, 3 -> x=0 with x_fall=1 on the response to 3; y=1 after the 0 response, then y=0 after 3. Idle cycles keep cnt and give out_valid=0.
- Macro defined, HI=5, LO=3, HOLD=1. Samples 6,4,4,2 -> x: 1,1,1,0; x_fall only at the 2 response.
- rst asserted together with in_valid=1 and in_data=7 while in PEND_HI -> next cycle all outputs 0, state LOW; the following samples 7 (HOLD=2) need two valid samples again before x_rise.

Source files
------------

// File: rtl/jg_threshold_detector.sv
// Registered threshold/zero detector with a debounced threshold flag and edge pulses.
// Optional release hysteresis: define JG_THRESHOLD_DETECTOR_HYSTERESIS_EN.
module jg_threshold_detector #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned HI_THRESH = 5,
    parameter int unsigned LO_THRESH = 4,
    parameter int unsigned HOLD      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             x,
    output logic             y,
    output logic             x_rise,
    output logic             x_fall
);

    localparam int unsigned      CW     = $clog2(HOLD + 1);
    localparam logic [CW-1:0]    HOLD_C = CW'(HOLD);
    localparam logic [WIDTH-1:0] HI_C   = WIDTH'(HI_THRESH);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        PEND_HI = 2'b01,
        HIGH    = 2'b10,
        PEND_LO = 2'b11
    } state_e;

    if (WIDTH < 1) begin : g_bad_width
        $error("jg_threshold_detector: WIDTH must be >= 1");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("jg_threshold_detector: HOLD must be >= 1");
    end
    if (LO_THRESH > HI_THRESH) begin : g_bad_lo
        $error("jg_threshold_detector: LO_THRESH must be <= HI_THRESH");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          out_valid_q, out_valid_d;
    logic          x_q, x_d;
    logic          y_q, y_d;
    logic          x_rise_q, x_rise_d;
    logic          x_fall_q, x_fall_d;
    logic          above;
    logic          below;

    assign above = (in_data >= HI_C);

`ifdef JG_THRESHOLD_DETECTOR_HYSTERESIS_EN
    localparam logic [WIDTH-1:0] LO_C = WIDTH'(LO_THRESH);
    assign below = (in_data < LO_C);
`else
    assign below = !above;
`endif

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOW;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            x_rise_q    <= 1'b0;
            x_fall_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_rise_q    <= x_rise_d;
            x_fall_q    <= x_fall_d;
        end
    end

    // Pending states only move on valid samples; idle cycles freeze the run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            case (state_q)
                LOW: begin
                    if (above) begin
                        if (HOLD == 1) begin
                            state_d = HIGH;
                        end else begin
                            state_d = PEND_HI;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (above) begin
                        if (cnt_inc == HOLD_C) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                end
                HIGH: begin
                    if (below) begin
                        if (HOLD == 1) begin
                            state_d = LOW;
                        end else begin
                            state_d = PEND_LO;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (below) begin
                        if (cnt_inc == HOLD_C) begin
                            state_d = LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Edge pulses fall out of comparing the next flag with the current one.
    always_comb begin
        x_d         = (state_d == HIGH) || (state_d == PEND_LO);
        x_rise_d    = x_d && !x_q;
        x_fall_d    = !x_d && x_q;
        out_valid_d = in_valid;
        y_d         = in_valid ? (in_data == '0) : y_q;
    end

    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign x_rise    = x_rise_q;
    assign x_fall    = x_fall_q;

endmodule
